// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and receiver/transmitter state encodings.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_e;
endpackage

// File: rtl/uart_rx_core.sv
// Bit-level UART receiver: RX synchroniser, framing FSM and one-cycle write strobe.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BAUD_DIV  = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_i,
    output logic              wr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              perr_o,
    output logic              ferr_o
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] FULL_C = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_C = CW'(BAUD_DIV / 2 - 1);
    localparam logic [3:0] LAST_D = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              s1_q, s2_q, prev_q;
    logic              rx_s, expired, par_x;

    assign rx_s    = s2_q;
    assign expired = (cnt_q == '0);
    assign par_x   = (^sh_q) ^ rx_s;
    assign data_o  = sh_q;
    assign perr_o  = perr_q;
    assign ferr_o  = ferr_q | ~rx_s;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= rx_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Counter counts down to zero; every expiry reloads a full bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = expired ? FULL_C : cnt_q - CW'(1);
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        wr_o    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bcnt_d = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                cnt_d  = HALF_C;
                // Edge-only arming keeps a held-low line from restarting.
                if (prev_q && !rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (expired) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (expired) begin
                    sh_d = {rx_s, sh_q[DATA_W-1:1]};
                    if (bcnt_q == LAST_D) begin
                        bcnt_d  = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (expired) begin
                    perr_d  = (PARITY == PAR_ODD) ? ~par_x : par_x;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (expired) begin
                    if (bcnt_q == LAST_S) begin
                        wr_o    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d = ferr_q | ~rx_s;
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_rx_fifo_gen.sv
// UART receiver with first-word-fall-through character FIFO and sticky overrun flag.
module uart_rx_fifo_gen
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 5,
    parameter int BAUD_DIV  = 434,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX,
    input  logic              RD_EN,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] DATA,
    output logic              DATA_PERR,
    output logic              DATA_FERR,
    output logic              DATA_RDY,
    output logic [DEPTH:0]    LEVEL,
    output logic              FULL,
    output logic              OVERRUN
);
    localparam int N  = 2 ** DEPTH;
    localparam int EW = DATA_W + 2;

    logic              wr, wperr, wferr;
    logic [DATA_W-1:0] wdata;
    logic [EW-1:0]     mem_q [N];
    logic [DEPTH-1:0]  wptr_q, rptr_q;
    logic [DEPTH:0]    level_q, level_d;
    logic              full_q, rdy_q, ovr_q;
    logic              pop, push, drop;

    uart_rx_core #(
        .DATA_W   (DATA_W),
        .BAUD_DIV (BAUD_DIV),
        .PARITY   (PARITY),
        .STOP_BITS(STOP_BITS)
    ) u_core (
        .CLK   (CLK),
        .RST   (RST),
        .rx_i  (RX),
        .wr_o  (wr),
        .data_o(wdata),
        .perr_o(wperr),
        .ferr_o(wferr)
    );

    // A pop in the write cycle frees the slot, so a full FIFO still accepts.
    assign pop     = RD_EN & rdy_q;
    assign push    = wr & (~full_q | pop);
    assign drop    = wr & full_q & ~pop;
    assign level_d = level_q + {{DEPTH{1'b0}}, push} - {{DEPTH{1'b0}}, pop};

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= {wferr, wperr, wdata};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + DEPTH'(1);
            if (pop)  rptr_q <= rptr_q + DEPTH'(1);
            level_q <= level_d;
            full_q  <= (level_d == (DEPTH+1)'(N));
            rdy_q   <= (level_d != '0);
            ovr_q   <= drop | (ovr_q & ~CLR_ERR);
        end
    end

    assign {DATA_FERR, DATA_PERR, DATA} = mem_q[rptr_q];
    assign DATA_RDY = rdy_q;
    assign LEVEL    = level_q;
    assign FULL     = full_q;
    assign OVERRUN  = ovr_q;
endmodule

// File: doc/uart_rx_fifo_gen.md
UART_RX_FIFO_GEN -- requirements
Module: uart_rx_fifo_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning character data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DEPTH, default 5, meaning log2 of FIFO entry count (N = 2**DEPTH).
REQ-003 SHALL have parameter BAUD_DIV, default 434, meaning CLK cycles per bit period (legal >= 8).
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (1 or 2).
REQ-006 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port RX  input  1  asynchronous serial line; idle high.
REQ-009 SHALL have port RD_EN  input  1  pops the head entry when DATA_RDY=1.
REQ-010 SHALL have port CLR_ERR  input  1  clears the sticky OVERRUN flag.
REQ-011 SHALL have port DATA  output  DATA_W  head-entry character (first-word-fall-through).
REQ-012 SHALL have port DATA_PERR  output  1  parity error of the head entry.
REQ-013 SHALL have port DATA_FERR  output  1  framing error of the head entry.
REQ-014 SHALL have port DATA_RDY  output  1  FIFO non-empty; DATA/DATA_PERR/DATA_FERR valid.
REQ-015 SHALL have port LEVEL  output  DEPTH+1  number of occupied entries (0..N).
REQ-016 SHALL have port FULL  output  1  LEVEL == N.
REQ-017 SHALL have port OVERRUN  output  1  sticky flag: a received character was dropped.

Function
REQ-018 SHALL pass RX through a two-flop synchroniser before any use; total RX-to-FSM latency 2 cycles.
REQ-019 SHALL run receiver FSM states IDLE, START, DATA, PAR, STOP with one bit-period counter of width clog2(BAUD_DIV).
REQ-020 IDLE -> START on synchronised RX falling (1->0); counter loaded to BAUD_DIV/2 (integer division).
REQ-021 START: at counter expiry, RX=0 -> DATA with counter BAUD_DIV; RX=1 -> IDLE (glitch rejected, nothing written).
REQ-022 DATA: sample RX at each expiry, LSB first, into shift register; after DATA_W samples -> PAR if PARITY!=0 else STOP.
REQ-023 PAR: one sample; PERR = (XOR of data bits XOR parity bit) for even, its inverse for odd; PERR=0 when PARITY=0.
REQ-024 STOP: STOP_BITS samples; FERR=1 if any stop sample is 0.
REQ-025 On final stop-bit sample the FSM SHALL issue a one-cycle write of {FERR, PERR, data} and return to IDLE that same cycle.
REQ-026 After a framing error, the FSM SHALL re-arm only after RX is seen high (no false start on a held-low line/break).
REQ-027 FIFO SHALL use DEPTH-bit read/write pointers wrapping modulo N, plus an occupancy counter of DEPTH+1 bits.
REQ-028 Written entry SHALL appear at DATA/DATA_RDY on the cycle after the write cycle.
REQ-029 RD_EN with DATA_RDY=1 pops; next entry (or DATA_RDY=0) visible the following cycle; RD_EN with DATA_RDY=0 ignored.
REQ-030 Write when FULL with no same-cycle pop: character dropped, OVERRUN set next cycle, LEVEL unchanged.
REQ-031 Write and pop in the same cycle (including when FULL): both performed, LEVEL unchanged, no overrun.
REQ-032 CLR_ERR SHALL clear OVERRUN; if an overrun occurs in the same cycle, OVERRUN stays set (set wins).
REQ-033 LEVEL, FULL, DATA_RDY, OVERRUN SHALL be registered outputs.

Reset
REQ-034 RST low SHALL asynchronously force FSM=IDLE, pointers=0, LEVEL=0, DATA_RDY=0, FULL=0, OVERRUN=0, synchroniser flops=1.
REQ-035 Reset mid-frame SHALL abandon the partial character; no write occurs after RST deasserts until a new start bit.
REQ-036 FIFO storage array SHALL NOT be reset; DATA, DATA_PERR and DATA_FERR are don't-care while DATA_RDY=0.

Structure
REQ-037 Parity mode codes (NONE/EVEN/ODD) and FSM state encodings SHALL live in shared package uart_pkg, shared with the transmitter.
REQ-038 Bit-level receiver SHALL be sub-module uart_rx_core (synchroniser, FSM, write strobe); FIFO logic stays in uart_rx_fifo_gen.

Verification
REQ-039 Defaults, 'h55 sent at 115200 baud with 50 MHz CLK -> DATA='h55, DATA_RDY=1, PERR=FERR=0, LEVEL=1.
REQ-040 PARITY=1, 'h07 sent with wrong parity bit 0 -> DATA='h07, DATA_PERR=1.
REQ-041 Stop bit forced 0 on 'hA3 -> DATA_FERR=1; RX held low 3 frames afterwards -> LEVEL stays 1.
REQ-042 DEPTH=2, 5 chars no reads -> FULL=1, LEVEL=4, OVERRUN=1, reads return first 4 chars in order.
REQ-043 With FULL=1, pop on the write cycle -> LEVEL=4, OVERRUN=0; then CLR_ERR after earlier overrun -> OVERRUN=0.
REQ-044 RX low pulse of BAUD_DIV/4 cycles -> no write; RST pulsed mid-frame -> LEVEL=0, next full frame received correctly.
